// File: rtl/pattern110_tx.sv
// pattern110_tx: serial stimulus source for a "110" sequence detector.
// Takes a parallel pattern, a length and a repeat count over a valid/ready
// handshake, shifts the bits out MSB-first on `a`, and keeps a saturating
// golden count of the "110" occurrences it has emitted.
module pattern110_tx #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int REP_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MAX_LEN-1:0] pat_data,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic [REP_W-1:0]   pat_rep,
    input  logic               start_valid,
    output logic               start_ready,
    output logic               a,
    output logic               a_valid,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   exp_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t             state;
    logic [MAX_LEN-1:0] pat_al;   // latched pattern, first bit at the MSB
    logic [MAX_LEN-1:0] shreg;    // bits still to send in this repetition
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   bit_cnt;  // bits remaining after the one on `a`
    logic [REP_W-1:0]   rep_cnt;
    logic [1:0]         hist;     // last two emitted bits, newest in [0]

    logic [LEN_W-1:0]   len_c;
    logic [MAX_LEN-1:0] aligned;
    logic               accept;

    // Saturating increment of the match counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Left-align the pattern so the first bit to send always sits at the MSB;
    // pattern bits above the clamped length fall off the top.
    assign len_c   = (pat_len > MAX_LEN_L) ? MAX_LEN_L : pat_len;
    assign aligned = pat_data << (MAX_LEN_L - len_c);
    assign accept  = (state == ST_IDLE) && start_ready && start_valid;

    // Control FSM with registered outputs, shifter and golden match counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            start_ready <= 1'b0;
            a           <= 1'b0;
            a_valid     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            exp_count   <= '0;
            hist        <= '0;
            bit_cnt     <= '0;
            rep_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done        <= 1'b0;
                    a           <= 1'b0;
                    a_valid     <= 1'b0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                    if (accept) begin
                        pat_al      <= aligned;
                        len_q       <= len_c;
                        rep_cnt     <= pat_rep;
                        exp_count   <= '0;
                        hist        <= '0;
                        start_ready <= 1'b0;
                        if (len_c == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= ST_SEND;
                            busy    <= 1'b1;
                            a_valid <= 1'b1;
                            a       <= aligned[MAX_LEN-1];
                            shreg   <= aligned << 1;
                            bit_cnt <= len_c - 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    // The bit on `a` completes a "110" when it is 0 after two 1s;
                    // history deliberately runs across repetition boundaries.
                    hist <= {hist[0], a};
                    if (!a && hist == 2'b11) begin
                        exp_count <= sat_inc(exp_count);
                    end
                    if (bit_cnt == '0) begin
                        if (rep_cnt != '0) begin
                            rep_cnt <= rep_cnt - 1'b1;
                            bit_cnt <= len_q - 1'b1;
                            a       <= pat_al[MAX_LEN-1];
                            shreg   <= pat_al << 1;
                        end else begin
                            state   <= ST_DONE;
                            a       <= 1'b0;
                            a_valid <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                        a       <= shreg[MAX_LEN-1];
                        shreg   <= shreg << 1;
                    end
                end
                ST_DONE: begin
                    done        <= 1'b0;
                    start_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern110_tx.sv
// tb_pattern110_tx: drives two transmitters (8-bit and 2-bit golden counters)
// from the same stimulus and compares every cycle against a transaction-level
// model built from the bit stream each request should produce.
module tb_pattern110_tx;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int REP_W   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_W_S = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [MAX_LEN-1:0] pat_data;
    logic [LEN_W-1:0]   pat_len;
    logic [REP_W-1:0]   pat_rep;
    logic               start_valid;

    logic               start_ready, a, a_valid, busy, done;
    logic [CNT_W-1:0]   exp_count;
    logic               start_ready_s, a_s, a_valid_s, busy_s, done_s;
    logic [CNT_W_S-1:0] exp_count_s;

    int total = 0;
    int bad   = 0;
    int last_cnt = 0;

    always #5 clk = ~clk;

    pattern110_tx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .REP_W(REP_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset(reset), .pat_data(pat_data), .pat_len(pat_len),
        .pat_rep(pat_rep), .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .a_valid(a_valid), .busy(busy), .done(done), .exp_count(exp_count)
    );

    pattern110_tx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .REP_W(REP_W), .CNT_W(CNT_W_S)) u_sat (
        .clk(clk), .reset(reset), .pat_data(pat_data), .pat_len(pat_len),
        .pat_rep(pat_rep), .start_valid(start_valid), .start_ready(start_ready_s),
        .a(a_s), .a_valid(a_valid_s), .busy(busy_s), .done(done_s), .exp_count(exp_count_s)
    );

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    // Number of "110" occurrences fully contained in the first m bits.
    function automatic int count110(input bit q[$], input int m);
        int n;
        n = 0;
        for (int i = 2; i < m; i++)
            if (q[i-2] && q[i-1] && !q[i]) n++;
        return n;
    endfunction

    task automatic expect_out(input string w, input int ea, input int eav, input int eb,
                              input int ed, input int esr, input int ecnt);
        chk({w, " a"},           int'(a),           ea);
        chk({w, " a_valid"},     int'(a_valid),     eav);
        chk({w, " busy"},        int'(busy),        eb);
        chk({w, " done"},        int'(done),        ed);
        chk({w, " start_ready"}, int'(start_ready), esr);
        chk({w, " exp_count"},   int'(exp_count),   sat(ecnt, CNT_W));
        chk({w, " s.a"},         int'(a_s),         ea);
        chk({w, " s.a_valid"},   int'(a_valid_s),   eav);
        chk({w, " s.busy"},      int'(busy_s),      eb);
        chk({w, " s.done"},      int'(done_s),      ed);
        chk({w, " s.start_ready"}, int'(start_ready_s), esr);
        chk({w, " s.exp_count"}, int'(exp_count_s), sat(ecnt, CNT_W_S));
    endtask

    task automatic scramble();
        pat_data = MAX_LEN'($urandom);
        pat_len  = LEN_W'($urandom);
        pat_rep  = REP_W'($urandom);
    endtask

    // Reset applied for one edge from an arbitrary point, then released.
    task automatic reset_abort(input string w);
        reset = 1'b1;
        start_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        expect_out({w, " rst"}, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        expect_out({w, " rel"}, 0, 0, 0, 0, 1, 0);
        last_cnt = 0;
    endtask

    // Called at a negedge of an idle cycle with start_ready high.
    // abort_at: 0 none, >0 reset in that cycle after the check, -1 random cycle.
    task automatic txn(input logic [MAX_LEN-1:0] d, input int len, input int rep,
                       input bit keep, input int abort_at);
        bit    bits[$];
        int    l, n, ab;
        string w;
        l = (len > MAX_LEN) ? MAX_LEN : len;
        for (int r = 0; r <= rep; r++)
            for (int i = l - 1; i >= 0; i--)
                bits.push_back(d[i]);
        n  = bits.size();
        ab = (abort_at < 0) ? $urandom_range(1, n + 2) : abort_at;
        pat_data    = d;
        pat_len     = len[LEN_W-1:0];
        pat_rep     = rep[REP_W-1:0];
        start_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= n + 2; c++) begin
            @(negedge clk);
            w = $sformatf("d=%h len=%0d rep=%0d cyc=%0d", d, len, rep, c);
            if (c <= n)
                expect_out(w, bits[c-1], 1, 1, 0, 0, count110(bits, c - 1));
            else if (c == n + 1)
                expect_out(w, 0, 0, 0, 1, 0, count110(bits, n));
            else
                expect_out(w, 0, 0, 0, 0, 1, count110(bits, n));
            if (ab == c) begin
                reset_abort(w);
                return;
            end
            scramble();
            start_valid = (c == n + 2) ? keep : 1'($urandom_range(0, 1));
        end
        last_cnt = count110(bits, n);
    endtask

    task automatic idle(input int k);
        start_valid = 1'b0;
        for (int i = 0; i < k; i++) begin
            scramble();
            @(negedge clk);
            expect_out($sformatf("idle%0d", i), 0, 0, 0, 0, 1, last_cnt);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit keep;
        reset = 1'b1;
        start_valid = 1'b1;
        scramble();
        @(posedge clk);
        @(negedge clk);
        expect_out("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        expect_out("post_reset", 0, 0, 0, 0, 1, 0);
        start_valid = 1'b0;

        // Single pattern and repetitions.
        txn(16'b110, 3, 0, 1'b0, 0);
        chk("t1 exp_count", int'(exp_count), 1);
        idle(2);
        txn(16'b110, 3, 2, 1'b0, 0);
        chk("t2 exp_count", int'(exp_count), 3);
        // Match spanning the repetition boundary.
        txn(16'b0111, 4, 1, 1'b0, 0);
        chk("t3 exp_count", int'(exp_count), 1);
        // Zero length, with and without repeats.
        txn(16'hFFFF, 0, 0, 1'b0, 0);
        chk("t4 exp_count", int'(exp_count), 0);
        txn(16'h1234, 0, 7, 1'b0, 0);
        idle(1);
        // start_valid held through a len=4 transaction: one accept, next at E+6.
        txn(16'b1101, 4, 0, 1'b1, 0);
        txn(16'b0110, 4, 0, 1'b0, 0);
        // Reset in the third bit cycle of a len=8 send.
        txn(16'b11011011, 8, 0, 1'b0, 3);
        idle(1);
        // Saturation of the 2-bit counter, plain count on the 8-bit one.
        txn(16'b110, 3, 5, 1'b0, 0);
        chk("t6 exp_count", int'(exp_count), 6);
        chk("t6 sat exp_count", int'(exp_count_s), 3);
        // Over-long length clamps to 16 bits.
        txn(16'hDB6D, 31, 0, 1'b0, 0);
        // Reset while in the done cycle.
        txn(16'b110, 3, 0, 1'b0, 4);

        for (int i = 0; i < 40; i++) begin
            keep = 1'($urandom_range(0, 1));
            txn(MAX_LEN'($urandom), $urandom_range(0, 31), $urandom_range(0, 15), keep,
                ($urandom_range(0, 5) == 0) ? -1 : 0);
            if (!keep) idle($urandom_range(0, 3));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
